mem_stage_dcache: RTL and testbench
===================================

Name: mem_stage_dcache

Overview:
Memory-access stage of the pipelined-plus-cache core. It sits between the execute/memory pipeline register and the memory/writeback register. It services loads and stores through a direct-mapped, write-through, no-write-allocate data cache in front of a req/ack backing-memory port. It produces the formatted load data, a stage-valid for the memory/writeback register, and a stall that freezes the upstream stages and the memory/writeback register.

Parameters:
DATA_WIDTH, 32, data word width (only 32 supported)
ADDR_WIDTH, 32, byte address width
INDEX_BITS, 6, log2(number of lines); line = one 32-bit word; tag = ADDR_WIDTH-INDEX_BITS-2 bits

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
valid_m  in  1  instruction in stage is valid
MemRead_m  in  1  load
MemWrite_m  in  1  store (never set together with MemRead_m)
funct3_m  in  3  access size/sign (RV32I load/store funct3)
ALUResult_m  in  ADDR_WIDTH  byte address
WriteData_m  in  DATA_WIDTH  store data, unshifted
ReadData_m  out  DATA_WIDTH  formatted load result
valid_out  out  1  to memory/writeback register valid input
stall_m  out  1  1 = hold upstream and memory/writeback register (drives their en low)
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = read
mem_addr  out  ADDR_WIDTH  word-aligned address ([1:0]=0)
mem_wdata  out  DATA_WIDTH  lane-aligned store data
mem_wstrb  out  4  byte strobes (0 on reads)
mem_ack  in  1  one-cycle completion pulse
mem_rdata  in  DATA_WIDTH  read word, valid with mem_ack

Behaviour:
- Reset: all line valid bits 0, state IDLE; mem_req, mem_we, mem_wstrb, stall_m, valid_out 0; mem_addr, mem_wdata 0. Reset mid-transaction abandons it; the backing memory tolerates a dropped ack.
- States: IDLE, RD_MISS, WR_THRU, DONE.
- Lookup (combinational, IDLE): index = addr[INDEX_BITS+1:2], hit = valid[index] and tag match.
- Non-memory or valid_m=0: no stall; ReadData_m = 0; valid_out = valid_m.
- Load hit in IDLE: ReadData_m same cycle; stall_m=0; latency 0.
- Load miss: IDLE->RD_MISS. mem_req=1, mem_we=0. mem_req is held and stall_m=1 until the mem_ack cycle. On ack: write line (data, tag, valid), latch mem_rdata into resp_q, go to DONE.
- Store (hit or miss): IDLE->WR_THRU. mem_req=1, mem_we=1. mem_req is held and stall_m=1 until ack. On ack: if hit, merge strobed bytes into the line (hit evaluated at entry and held); a miss allocates nothing. Then go to DONE.
- DONE: stall_m=0 for exactly one cycle. For loads, ReadData_m is formatted from resp_q. Always returns to IDLE.
- Miss or store cost = memory latency + 1 cycle (DONE).
- valid_out = valid_m & ~stall_m.
- Upstream holds all inputs stable while stall_m=1.
- mem_addr, mem_we, mem_wdata and mem_wstrb are registered and stable while mem_req=1. mem_req drops the cycle after ack.
- Load format uses addr[1:0]:
  - LB: sign-extend byte; LBU: zero-extend byte.
  - LH: sign-extend half at addr[1]; LHU: zero-extend half; addr[0] is ignored for halves.
  - LW: whole word; addr[1:0] ignored.
  - Other funct3 values return the word unmodified.
- Store format:
  - SB: wstrb = 1<<addr[1:0], byte replicated on all lanes.
  - SH: wstrb = 0011 or 1100 per addr[1], half replicated.
  - SW: wstrb = 1111.
- Simultaneous events: mem_ack outside RD_MISS/WR_THRU is ignored.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], both saturating and reset to 0.
  - hit_count increments once per load hit accepted in IDLE.
  - miss_count increments on each IDLE->RD_MISS transition.
  - Stores are not counted.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Cold LW 0x100, memory latency 3, rdata 0xDEADBEEF -> stall_m high 4 cycles, valid_out=1 with ReadData_m=0xDEADBEEF in the DONE cycle. An immediate repeat LW 0x100 hits with no stall.
- After filling 0x100, LB 0x103 -> 0xFFFFFFDE; LBU 0x103 -> 0x000000DE; LH 0x102 -> 0xFFFFDEAD; LHU 0x100 -> 0x0000BEEF; all zero-stall hits.
- SB 0x101 data 0x55 (hit) -> mem_we=1, wstrb=0010, wdata=0x55555555, stall until ack+1. A following LW 0x100 hits with 0xDEAD55EF.
- SW 0x200 (miss) then LW 0x200 -> store issues without allocation; the load misses and issues a memory read.
- Aliasing: fill 0x100, then LW 0x100+(4<<INDEX_BITS) (same index, different tag) -> miss and refill. LW 0x100 then misses again.
- Assert rst_n low during RD_MISS -> mem_req, stall_m and valid_out go 0 asynchronously. After release, LW 0x100 misses (cache invalidated) and a late stale ack in IDLE is ignored.

Source files
------------

// File: rtl/mem_stage_dcache.sv
// Memory-access stage with a direct-mapped, write-through, no-write-allocate data cache.
// Optional macro DCACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module mem_stage_dcache #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int INDEX_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  valid_m,
    input  logic                  MemRead_m,
    input  logic                  MemWrite_m,
    input  logic [2:0]            funct3_m,
    input  logic [ADDR_WIDTH-1:0] ALUResult_m,
    input  logic [DATA_WIDTH-1:0] WriteData_m,
    output logic [DATA_WIDTH-1:0] ReadData_m,
    output logic                  valid_out,
    output logic                  stall_m,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_ack,
`ifdef DCACHE_STATS_EN
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
`else
    input  logic [DATA_WIDTH-1:0] mem_rdata
`endif
);

    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, DONE} state_e;

    state_e                  state_q, state_d;
    logic [LINES-1:0]        valid_q;
    logic [TAG_BITS-1:0]     tag_q  [LINES];
    logic [DATA_WIDTH-1:0]   data_q [LINES];
    logic [DATA_WIDTH-1:0]   resp_q;
    logic                    wr_hit_q, wr_hit_d;
    logic                    mem_req_q, mem_req_d;
    logic                    mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_wstrb_q, mem_wstrb_d;

    logic [INDEX_BITS-1:0]   index, mem_idx;
    logic [TAG_BITS-1:0]     tag, mem_tag;
    logic                    hit;
    logic                    stall, fill, merge;
    logic [DATA_WIDTH-1:0]   rdata, merged;
    logic [DATA_WIDTH-1:0]   st_wdata;
    logic [3:0]              st_wstrb;

    function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    assign index   = ALUResult_m[INDEX_BITS+1:2];
    assign tag     = ALUResult_m[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit     = valid_q[index] && (tag_q[index] == tag);
    assign mem_idx = mem_addr_q[INDEX_BITS+1:2];
    assign mem_tag = mem_addr_q[ADDR_WIDTH-1:INDEX_BITS+2];

    always_comb begin
        st_wdata = WriteData_m;
        st_wstrb = 4'b1111;
        case (funct3_m[1:0])
            2'b00: begin
                st_wdata = {4{WriteData_m[7:0]}};
                st_wstrb = 4'b0001 << ALUResult_m[1:0];
            end
            2'b01: begin
                st_wdata = {2{WriteData_m[15:0]}};
                st_wstrb = ALUResult_m[1] ? 4'b1100 : 4'b0011;
            end
            default: ;
        endcase
    end

    // Write-hit merge targets the line latched with the request, not the live address.
    always_comb begin
        merged = data_q[mem_idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (mem_wstrb_q[i]) merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_hit_d    = wr_hit_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        stall       = 1'b0;
        fill        = 1'b0;
        merge       = 1'b0;
        rdata       = '0;
        case (state_q)
            IDLE: begin
                if (valid_m && MemRead_m) begin
                    if (hit) begin
                        rdata = load_fmt(data_q[index], funct3_m, ALUResult_m[1:0]);
                    end else begin
                        stall       = 1'b1;
                        state_d     = RD_MISS;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = {ALUResult_m[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_d = '0;
                        mem_wstrb_d = '0;
                    end
                end else if (valid_m && MemWrite_m) begin
                    stall       = 1'b1;
                    state_d     = WR_THRU;
                    wr_hit_d    = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {ALUResult_m[ADDR_WIDTH-1:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_wstrb_d = st_wstrb;
                end
            end
            RD_MISS: begin
                stall = 1'b1;
                if (mem_ack) begin
                    fill      = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            WR_THRU: begin
                stall = 1'b1;
                if (mem_ack) begin
                    merge     = wr_hit_q;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (valid_m && MemRead_m) rdata = load_fmt(resp_q, funct3_m, ALUResult_m[1:0]);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            resp_q      <= '0;
            wr_hit_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_hit_q    <= wr_hit_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            if (fill) begin
                valid_q[mem_idx] <= 1'b1;
                resp_q           <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_q[mem_idx] <= mem_rdata;
            tag_q[mem_idx]  <= mem_tag;
        end else if (merge) begin
            data_q[mem_idx] <= merged;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == IDLE) && valid_m && MemRead_m && hit;
    assign miss_evt = (state_q == IDLE) && valid_m && MemRead_m && !hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != '1))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_evt && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

    // Reset forces the handshake outputs low immediately, even with a request held upstream.
    assign stall_m    = rst_n & stall;
    assign valid_out  = rst_n & valid_m & ~stall;
    assign ReadData_m = rdata;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_mem_stage_dcache.sv
// Scoreboard bench for mem_stage_dcache: reference memory model, randomized loads/stores.
module tb_mem_stage_dcache;

    localparam int IB    = 6;
    localparam int LINES = 1 << IB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_m, MemRead_m, MemWrite_m;
    logic [2:0]  funct3_m;
    logic [31:0] ALUResult_m, WriteData_m;
    logic [31:0] ReadData_m;
    logic        valid_out, stall_m;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    mem_stage_dcache #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .INDEX_BITS(IB)) dut (
        .clk(clk), .rst_n(rst_n), .valid_m(valid_m), .MemRead_m(MemRead_m),
        .MemWrite_m(MemWrite_m), .funct3_m(funct3_m), .ALUResult_m(ALUResult_m),
        .WriteData_m(WriteData_m), .ReadData_m(ReadData_m), .valid_out(valid_out),
        .stall_m(stall_m), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
    } req_t;

    logic [31:0] exp_q[$];
    req_t        req_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          mem_lat    = 1;
    bit          inject_stale = 0;

    logic [31:0] ref_mem [int unsigned];
    logic [31:0] bmem    [int unsigned];
    bit          ref_v   [LINES];
    int unsigned ref_t   [LINES];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] wa);
        if (wa == 32'h100) return 32'hDEADBEEF;
        return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] wa);
        if (!ref_mem.exists(wa)) ref_mem[wa] = init_word(wa);
        return ref_mem[wa];
    endfunction

    function automatic logic [31:0] rd_bmem(input logic [31:0] wa);
        if (!bmem.exists(wa)) bmem[wa] = init_word(wa);
        return bmem[wa];
    endfunction

    function automatic logic [7:0] rbyte(input logic [31:0] a);
        logic [31:0] w;
        w = rd_ref(a & ~32'h3);
        return 8'(w >> (8 * a[1:0]));
    endfunction

    function automatic void wbyte(input logic [31:0] a, input logic [7:0] v);
        logic [31:0] w;
        int unsigned sh;
        w  = rd_ref(a & ~32'h3);
        sh = 8 * a[1:0];
        ref_mem[a & ~32'h3] = (w & ~(32'hFF << sh)) | ({24'h0, v} << sh);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = rbyte(a);
        h = {rbyte((a & ~32'h1) + 32'd1), rbyte(a & ~32'h1)};
        case (f3)
            3'd0:    return {{24{b[7]}}, b};
            3'd1:    return {{16{h[15]}}, h};
            3'd4:    return {24'h0, b};
            3'd5:    return {16'h0, h};
            default: return rd_ref(a & ~32'h3);
        endcase
    endfunction

    function automatic void ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        case (f3)
            3'd0: wbyte(a, d[7:0]);
            3'd1: begin
                wbyte(a & ~32'h1, d[7:0]);
                wbyte((a & ~32'h1) + 32'd1, d[15:8]);
            end
            default: for (int k = 0; k < 4; k++) wbyte((a & ~32'h3) + 32'(k), 8'(d >> (8 * k)));
        endcase
    endfunction

    task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, input int lat);
        int          n;
        int          exp_stall;
        int unsigned idx, tg;
        bit          hit;
        req_t        r;
        logic [31:0] lane;
        logic [3:0]  strb;
        mem_lat     = lat;
        valid_m     = 1'b1;
        MemRead_m   = ld;
        MemWrite_m  = st;
        funct3_m    = f3;
        ALUResult_m = a;
        WriteData_m = wd;
        idx = (a >> 2) % LINES;
        tg  = a >> (IB + 2);
        hit = ref_v[idx] && (ref_t[idx] == tg);
        exp_stall = 0;
        if (ld) begin
            exp_q.push_back(ref_load(f3, a));
            if (!hit) begin
                r = '{1'b0, a & ~32'h3, 32'h0, 4'h0};
                req_q.push_back(r);
                ref_v[idx] = 1'b1;
                ref_t[idx] = tg;
                exp_stall  = lat + 1;
            end
        end else if (st) begin
            case (f3)
                3'd0:    begin lane = wd[7:0] * 32'h01010101;  strb = 4'b0001 << a[1:0]; end
                3'd1:    begin lane = wd[15:0] * 32'h00010001; strb = a[1] ? 4'b1100 : 4'b0011; end
                default: begin lane = wd;                      strb = 4'b1111; end
            endcase
            r = '{1'b1, a & ~32'h3, lane, strb};
            req_q.push_back(r);
            exp_q.push_back(32'h0);
            ref_store(f3, a, wd);
            exp_stall = lat + 1;
        end else begin
            exp_q.push_back(32'h0);
        end
        n = 0;
        @(negedge clk);
        while (stall_m && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("stall_cycles", n, exp_stall);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        valid_m    = 1'b0;
        MemRead_m  = 1'b0;
        MemWrite_m = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented stage result is checked against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            if (exp_q.size() == 0) chk("unexpected_valid_out", {31'h0, valid_out}, 32'h0);
            else chk("ReadData_m", ReadData_m, exp_q.pop_front());
        end
    end

    // Backing memory: acks after mem_lat request cycles, checks each new request.
    initial begin
        int   cnt;
        req_t e;
        cnt       = 0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_ack = 1'b0;
            if (mem_req) begin
                cnt++;
                if (cnt == 1) begin
                    if (req_q.size() == 0) chk("unexpected_mem_req", {31'h0, mem_req}, 32'h0);
                    else begin
                        e = req_q.pop_front();
                        chk("mem_addr", mem_addr, e.addr);
                        chk("mem_we_wstrb", {27'h0, mem_we, mem_wstrb}, {27'h0, e.we, e.strb});
                        if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                    end
                end
                if (cnt >= mem_lat) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        logic [31:0] w;
                        w = rd_bmem(mem_addr);
                        for (int k = 0; k < 4; k++)
                            if (mem_wstrb[k]) w[8*k +: 8] = mem_wdata[8*k +: 8];
                        bmem[mem_addr] = w;
                    end else begin
                        mem_rdata = rd_bmem(mem_addr);
                    end
                    cnt = 0;
                end
            end else begin
                cnt = 0;
                if (inject_stale) begin
                    mem_ack      = 1'b1;
                    mem_rdata    = 32'hBAD0BAD0;
                    inject_stale = 0;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        int          r;
        logic [2:0]  lf3 [6];
        lf3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3};
        for (int i = 0; i < LINES; i++) begin ref_v[i] = 0; ref_t[i] = 0; end
        rst_n = 1'b0;
        valid_m = 1'b0; MemRead_m = 1'b0; MemWrite_m = 1'b0;
        funct3_m = 3'd0; ALUResult_m = 32'h0; WriteData_m = 32'h0;
        #3;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_stall_valid", {30'h0, stall_m, valid_out}, 32'h0);
        chk("rst_we_wstrb", {27'h0, mem_we, mem_wstrb}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: cold miss, hits with every load format, store hit, no-allocate, aliasing.
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 3);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 3);
        do_op(1, 0, 3'd0, 32'h103, 32'h0, 2);
        do_op(1, 0, 3'd4, 32'h103, 32'h0, 2);
        do_op(1, 0, 3'd1, 32'h102, 32'h0, 2);
        do_op(1, 0, 3'd5, 32'h100, 32'h0, 2);
        do_op(0, 1, 3'd0, 32'h101, 32'h55, 2);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 2);
        do_op(0, 1, 3'd2, 32'h200, 32'h13579BDF, 1);
        do_op(1, 0, 3'd2, 32'h200, 32'h0, 2);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 1);
        do_op(1, 0, 3'd2, 32'h100 + (32'd4 << IB), 32'h0, 4);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 2);
        do_op(0, 0, 3'd0, 32'h0, 32'h0, 1);
        idle_cycle();

        // Randomized mix over a few aliasing lines.
        for (int i = 0; i < 250; i++) begin
            a = (32'($urandom_range(0, 3)) << (IB + 2)) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            r = $urandom_range(0, 11);
            if (r < 6)       do_op(1, 0, lf3[$urandom_range(0, 5)], a, 32'h0, $urandom_range(1, 4));
            else if (r < 9)  do_op(0, 1, 3'($urandom_range(0, 2)), a, $urandom, $urandom_range(1, 4));
            else if (r < 10) do_op(0, 0, 3'd0, a, 32'h0, 1);
            else             idle_cycle();
        end

        // Reset in the middle of a read miss, then a stale ack while idle.
        mem_lat = 4;
        valid_m = 1'b1; MemRead_m = 1'b1; MemWrite_m = 1'b0;
        funct3_m = 3'd2; ALUResult_m = 32'h300;
        if (!(ref_v[0] && ref_t[0] == (32'h300 >> (IB + 2))))
            req_q.push_back('{1'b0, 32'h300, 32'h0, 4'h0});
        else
            exp_q.push_back(ref_load(3'd2, 32'h300));
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midreset_stall_valid", {30'h0, stall_m, valid_out}, 32'h0);
        exp_q.delete();
        for (int i = 0; i < LINES; i++) ref_v[i] = 0;
        valid_m = 1'b0; MemRead_m = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        inject_stale = 1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("stale_ack_no_req", {31'h0, mem_req}, 32'h0);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 2);
        do_op(1, 0, 3'd2, 32'h100, 32'h0, 2);
        idle_cycle();
        idle_cycle();

        chk("pending_responses", exp_q.size(), 32'h0);
        chk("pending_mem_reqs", req_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
